booth_iter_mult: RTL



---
 rtl/booth_iter_mult.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/booth_iter_mult.sv
// booth_iter_mult
//
// Iterative radix-4 Booth multiplier covering the RV64 MUL/MULH/MULHSU/MULHU
// family. Operands are captured on accept and extended to W = XLEN+2 bits.
// PP_PER_CYC Booth partial products are then accumulated on each BUSY cycle.
// The selected product half is held in DONE until the consumer takes it.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_valid      operands valid (accepted when o_ready and no flush)
//   o_ready      block is idle and can take operands
//   i_x, i_y     multiplicand / multiplier, XLEN bits
//   i_x_signed   treat i_x as two's complement
//   i_y_signed   treat i_y as two's complement
//   i_high       1: return upper XLEN product bits, 0: lower XLEN bits
//   i_flush      abort whatever is in flight; overrides accept/handshake
//   o_valid      o_result is valid
//   i_ready      consumer accepts o_result
//   o_result     selected half of the product

module booth_iter_mult #(
  parameter int XLEN       = 64,
  parameter int PP_PER_CYC = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_x,
  input  logic [XLEN-1:0] i_y,
  input  logic            i_x_signed,
  input  logic            i_y_signed,
  input  logic            i_high,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int W   = XLEN + 2;
  localparam int NPP = W / 2;
  localparam int N   = (NPP + PP_PER_CYC - 1) / PP_PER_CYC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  // Only the low 2*XLEN product bits are ever observable on o_result, and
  // modular addition keeps those bits exact, so the accumulator stops there.
  localparam int AW  = 2 * XLEN;

  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   step_sum;
  logic [W-1:0]    x_reg;
  logic [W-1:0]    y_reg;
  logic            high_reg;
  logic [W-1:0]    x_ext;
  logic [W-1:0]    y_ext;
  logic [W:0]      y_pad;
  int              base;

  // Booth partial product k: pick 0/+-x/+-2x, sign-extend, weight by 4^k.
  function automatic logic [AW-1:0] booth_pp(input logic [W-1:0] xm,
                                             input logic [2:0]   sel,
                                             input int           k);
    logic [AW-1:0] xs;
    logic [AW-1:0] mag;
    xs = {{(AW-W){xm[W-1]}}, xm};
    case (sel)
      3'b001, 3'b010: mag = xs;
      3'b011:         mag = xs << 1;
      3'b100:         mag = -(xs << 1);
      3'b101, 3'b110: mag = -xs;
      default:        mag = '0;
    endcase
    return mag << (2 * k);
  endfunction

  assign x_ext = i_x_signed ? {{2{i_x[XLEN-1]}}, i_x} : {2'b00, i_x};
  assign y_ext = i_y_signed ? {{2{i_y[XLEN-1]}}, i_y} : {2'b00, i_y};

  // Appending a zero below the multiplier supplies y[-1] = 0 for k = 0.
  assign y_pad = {y_reg, 1'b0};
  assign base  = int'(cnt) * PP_PER_CYC;

  // Sum of the partial products handled this step; indices past the last
  // Booth digit contribute nothing, which zero-pads the final step.
  always_comb begin
    step_sum = '0;
    for (int j = 0; j < PP_PER_CYC; j++) begin
      if (base + j < NPP) begin
        step_sum = step_sum + booth_pp(x_reg, y_pad[2*(base+j) +: 3], base + j);
      end
    end
  end

  // Next-state and handshake outputs; flush beats both accept and handshake.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid && !i_flush) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_next = IDLE;
        end else if (cnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_flush || i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand capture and accumulation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
      high_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        x_reg    <= x_ext;
        y_reg    <= y_ext;
        high_reg <= i_high;
        cnt      <= '0;
        acc      <= '0;
      end else if (state == BUSY && !i_flush) begin
        acc <= acc + step_sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // acc only changes in BUSY, so the result is stable throughout DONE.
  assign o_result = high_reg ? acc[AW-1:XLEN] : acc[XLEN-1:0];

endmodule
